cond_unit: RTL and testbench

COND_UNIT -- requirements
Module: cond_unit

---
 rtl/cond_pkg.sv | 29 ++
 rtl/cond_unit_if.sv | 37 +++
 rtl/cond_check.sv | 39 +++
 rtl/cond_unit.sv | 103 ++++++++++
 tb/tb_cond_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the ARM-style condition unit: the condition-field
// encoding and the bit positions of N, Z, C and V in the flag vector.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Execute-stage bundle in, registered write-back bundle out, plus the
// architectural flag register made visible to the outside.
interface cond_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  cond;
  logic [1:0]  flag_w;
  logic        pcs;
  logic        reg_w;
  logic        mem_w;
  logic [3:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        pcs_en;
  logic        reg_w_en;
  logic        mem_w_en;
  logic        cond_ex;
  logic [3:0]  flags_q;

  modport master (
    output in_valid, alu_result, alu_flags, cond, flag_w, pcs, reg_w, mem_w, rd,
           out_ready,
    input  in_ready, out_valid, out_result, out_rd, pcs_en, reg_w_en, mem_w_en,
           cond_ex, flags_q
  );

  modport slave (
    input  in_valid, alu_result, alu_flags, cond, flag_w, pcs, reg_w, mem_w, rd,
           out_ready,
    output in_ready, out_valid, out_result, out_rd, pcs_en, reg_w_en, mem_w_en,
           cond_ex, flags_q
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against a {N,Z,C,V} vector.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition stage: evaluates the condition field against the current flags,
// gates the write requests, updates the flag register and registers the bundle.
module cond_unit
  import cond_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  cond_unit_if.slave bus
);

  logic        out_valid_q,  out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [3:0]  out_rd_q,     out_rd_d;
  logic        cond_ex_q,    cond_ex_d;
  logic        pcs_en_q,     pcs_en_d;
  logic        reg_w_en_q,   reg_w_en_d;
  logic        mem_w_en_q,   mem_w_en_d;
  logic [3:0]  flags_q,      flags_d;

  logic pass;
  logic in_ready;
  logic accept;

  cond_check u_cond_check (
    .cond  (bus.cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    cond_ex_d    = cond_ex_q;
    pcs_en_d     = pcs_en_q;
    reg_w_en_d   = reg_w_en_q;
    mem_w_en_d   = mem_w_en_q;
    flags_d      = flags_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_result_d = bus.alu_result;
      out_rd_d     = bus.rd;
      cond_ex_d    = pass;
      pcs_en_d     = bus.pcs   && pass;
      reg_w_en_d   = bus.reg_w && pass;
      mem_w_en_d   = bus.mem_w && pass;
    end else if (bus.out_ready) begin
      // Drained with nothing behind it: drop the enables with out_valid.
      out_valid_d = 1'b0;
      pcs_en_d    = 1'b0;
      reg_w_en_d  = 1'b0;
      mem_w_en_d  = 1'b0;
    end

    if (accept && pass) begin
      if (bus.flag_w[1]) begin
        flags_d[N_IDX] = bus.alu_flags[N_IDX];
        flags_d[Z_IDX] = bus.alu_flags[Z_IDX];
      end
      if (bus.flag_w[0]) begin
        flags_d[C_IDX] = bus.alu_flags[C_IDX];
        flags_d[V_IDX] = bus.alu_flags[V_IDX];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_rd_q     <= 4'd0;
      cond_ex_q    <= 1'b0;
      pcs_en_q     <= 1'b0;
      reg_w_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      flags_q      <= 4'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      cond_ex_q    <= cond_ex_d;
      pcs_en_q     <= pcs_en_d;
      reg_w_en_q   <= reg_w_en_d;
      mem_w_en_q   <= mem_w_en_d;
      flags_q      <= flags_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_rd     = out_rd_q;
  assign bus.cond_ex    = cond_ex_q;
  assign bus.pcs_en     = pcs_en_q;
  assign bus.reg_w_en   = reg_w_en_q;
  assign bus.mem_w_en   = mem_w_en_q;
  assign bus.flags_q    = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit with hand-computed expectations.
module tb_cond_unit;
  import cond_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cond_unit_if bus ();

  cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic [31:0] res, input logic [3:0] r,
                       input logic p, input logic rw, input logic mw);
    bus.in_valid   = 1'b1;
    bus.cond       = c;
    bus.flag_w     = fw;
    bus.alu_flags  = af;
    bus.alu_result = res;
    bus.rd         = r;
    bus.pcs        = p;
    bus.reg_w      = rw;
    bus.mem_w      = mw;
  endtask

  // Advance one rising edge and settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'h0, 2'b00, 4'h0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    bus.in_valid  = 1'b0;

    #2;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_flags", 32'(bus.flags_q), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    #2 rst_n = 1'b1;

    // First accepted bundle after reset: AL with full flag write.
    drive(4'hE, 2'b11, 4'b0100, 32'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    check("first_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("al_out_valid", 32'(bus.out_valid), 32'd1);
    check("al_cond_ex", 32'(bus.cond_ex), 32'd1);
    check("al_flags", 32'(bus.flags_q), 32'b0100);
    check("al_reg_w_en", 32'(bus.reg_w_en), 32'd1);
    check("al_out_rd", 32'(bus.out_rd), 32'd3);

    // NE fails with Z=1: no enable, no flag write.
    drive(4'h1, 2'b11, 4'b1111, 32'hDEADBEEF, 4'd5, 1'b0, 1'b1, 1'b0);
    step();
    check("ne_cond_ex", 32'(bus.cond_ex), 32'd0);
    check("ne_reg_w_en", 32'(bus.reg_w_en), 32'd0);
    check("ne_flags_hold", 32'(bus.flags_q), 32'b0100);
    check("ne_out_result", bus.out_result, 32'hDEADBEEF);
    check("ne_out_rd", 32'(bus.out_rd), 32'd5);

    // CMP then GE / LT back to back against the freshly written flags.
    drive(4'hE, 2'b11, 4'b1000, 32'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("cmp_flags", 32'(bus.flags_q), 32'b1000);
    drive(4'hA, 2'b00, 4'b0000, 32'd2, 4'd1, 1'b0, 1'b1, 1'b0);
    step();
    check("ge_cond_ex", 32'(bus.cond_ex), 32'd0);
    check("ge_reg_w_en", 32'(bus.reg_w_en), 32'd0);
    drive(4'hB, 2'b00, 4'b0000, 32'd3, 4'd2, 1'b0, 1'b0, 1'b1);
    step();
    check("lt_cond_ex", 32'(bus.cond_ex), 32'd1);
    check("lt_mem_w_en", 32'(bus.mem_w_en), 32'd1);

    // Partial flag writes.
    drive(4'hE, 2'b11, 4'b1010, 32'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("set_1010", 32'(bus.flags_q), 32'b1010);
    drive(4'hE, 2'b10, 4'b0111, 32'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("fw10_nz_only", 32'(bus.flags_q), 32'b0110);
    drive(4'hE, 2'b01, 4'b0001, 32'd6, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("fw01_cv_only", 32'(bus.flags_q), 32'b0101);
    drive(4'hE, 2'b00, 4'b1111, 32'd7, 4'd0, 1'b0, 1'b0, 1'b0);
    step();
    check("fw00_hold", 32'(bus.flags_q), 32'b0101);

    // flags now N=0 Z=1 C=0 V=1
    drive(4'hF, 2'b11, 4'b1111, 32'd8, 4'd0, 1'b1, 1'b1, 1'b1);
    step();
    check("nv_cond_ex", 32'(bus.cond_ex), 32'd0);
    check("nv_pcs_en", 32'(bus.pcs_en), 32'd0);
    check("nv_flags_hold", 32'(bus.flags_q), 32'b0101);
    drive(4'h9, 2'b00, 4'b0000, 32'd9, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("ls_pcs_en", 32'(bus.pcs_en), 32'd1);
    drive(4'h8, 2'b00, 4'b0000, 32'd10, 4'd0, 1'b1, 1'b0, 1'b0);
    step();
    check("hi_cond_ex", 32'(bus.cond_ex), 32'd0);
    drive(4'hC, 2'b00, 4'b0000, 32'd11, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    check("gt_cond_ex", 32'(bus.cond_ex), 32'd0);
    drive(4'hD, 2'b00, 4'b0000, 32'd12, 4'd0, 1'b0, 1'b1, 1'b0);
    step();
    check("le_reg_w_en", 32'(bus.reg_w_en), 32'd1);

    // Stall with a waiting bundle behind it.
    drive(4'hE, 2'b11, 4'b1000, 32'h0000AAAA, 4'd7, 1'b0, 1'b1, 1'b0);
    step();
    check("pre_stall_flags", 32'(bus.flags_q), 32'b1000);
    bus.out_ready = 1'b0;
    drive(4'hE, 2'b11, 4'b0100, 32'h0000BBBB, 4'd8, 1'b0, 1'b1, 1'b0);
    #1;
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", bus.out_result, 32'h0000AAAA);
      check("stall_rd", 32'(bus.out_rd), 32'd7);
      check("stall_flags", 32'(bus.flags_q), 32'b1000);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready_hold", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check("release_result", bus.out_result, 32'h0000BBBB);
    check("release_flags", 32'(bus.flags_q), 32'b0100);
    drive(4'hE, 2'b11, 4'b0010, 32'h0000CCCC, 4'd9, 1'b0, 1'b1, 1'b0);
    step();
    check("stream_result", bus.out_result, 32'h0000CCCC);
    check("stream_flags", 32'(bus.flags_q), 32'b0010);
    check("stream_valid", 32'(bus.out_valid), 32'd1);

    // Drain with no new bundle.
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_reg_w_en", 32'(bus.reg_w_en), 32'd0);

    // Asynchronous reset with a bundle in flight.
    drive(4'hE, 2'b11, 4'b1001, 32'h12345678, 4'd4, 1'b1, 1'b1, 1'b1);
    step();
    check("inflight_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_flags", 32'(bus.flags_q), 32'd0);
    check("async_rst_result", bus.out_result, 32'd0);
    check("async_rst_pcs_en", 32'(bus.pcs_en), 32'd0);
    step();
    #2 rst_n = 1'b1;
    drive(4'hE, 2'b11, 4'b0011, 32'h0BADF00D, 4'd6, 1'b0, 1'b0, 1'b1);
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_result", bus.out_result, 32'h0BADF00D);
    check("post_rst_flags", 32'(bus.flags_q), 32'b0011);
    check("post_rst_mem_w_en", 32'(bus.mem_w_en), 32'd1);

    bus.in_valid = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
